morse_ram_sequencer: RTL

- Sequences the shared 32x10 Morse RAM through one game round: START, P1TURN, P2TURN, RESULT.
- In P1TURN, writes player 1's Morse words to successive addresses.
- In P2TURN, reads them back, compares each one against player 2's word and keeps a score.
- Sits between the player input blocks and ram32x10. It owns all RAM address, write-enable and turn sequencing in the game top level.

---
 rtl/morse_ram_if.sv | 33 +++
 rtl/morse_ram_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/morse_ram_if.sv
// Bus between the Morse RAM sequencer and its environment (player inputs, ram32x10).
// master: the sequencer; slave: player pulse sources plus the RAM read port.
interface morse_ram_if #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 5
);
  logic              done_pulse;
  logic              next_pulse;
  logic [DATA_W-1:0] p1_value;
  logic [DATA_W-1:0] p2_value;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [1:0]        state;
  logic [ADDR_W:0]   wr_count;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   score;
  logic              last_match;
  logic              game_over;

  modport master (
    input  done_pulse, next_pulse, p1_value, p2_value, ram_q,
    output ram_addr, ram_data, ram_wren, state, wr_count, rd_ptr, score,
           last_match, game_over
  );

  modport slave (
    output done_pulse, next_pulse, p1_value, p2_value, ram_q,
    input  ram_addr, ram_data, ram_wren, state, wr_count, rd_ptr, score,
           last_match, game_over
  );
endinterface

// File: rtl/morse_ram_sequencer.sv
// Runs one game round over the shared Morse RAM: player 1 stores words,
// player 2 compares against them, and the block keeps the score.
module morse_ram_sequencer #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic       clock_1hz,
  input  logic       resetn,
  morse_ram_if.master bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [1:0] ST_START  = 2'd0;
  localparam logic [1:0] ST_P1TURN = 2'd1;
  localparam logic [1:0] ST_P2TURN = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  logic [1:0]       state_q,      state_d;
  logic [CNT_W-1:0] wr_count_q,   wr_count_d;
  logic [CNT_W-1:0] rd_ptr_q,     rd_ptr_d;
  logic [CNT_W-1:0] score_q,      score_d;
  logic             last_match_q, last_match_d;
  logic             rd_ready_q,   rd_ready_d;
  logic             game_over_q,  game_over_d;

  logic             ram_wren_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic             space_c;
  logic             match_c;
  logic [CNT_W-1:0] rd_ptr_inc_c;

  assign space_c      = (wr_count_q < CNT_W'(DEPTH));
  assign match_c      = (bus.p2_value == bus.ram_q);
  assign rd_ptr_inc_c = rd_ptr_q + CNT_W'(1);

  // Next-state, counter updates and the combinational RAM controls.
  always_comb begin
    state_d      = state_q;
    wr_count_d   = wr_count_q;
    rd_ptr_d     = rd_ptr_q;
    score_d      = score_q;
    last_match_d = last_match_q;
    rd_ready_d   = rd_ready_q;
    ram_wren_c   = 1'b0;
    ram_addr_c   = wr_count_q[ADDR_W-1:0];

    case (state_q)
      ST_START: begin
        if (bus.done_pulse) begin
          state_d      = ST_P1TURN;
          wr_count_d   = '0;
          rd_ptr_d     = '0;
          score_d      = '0;
          last_match_d = 1'b0;
        end
      end

      ST_P1TURN: begin
        ram_addr_c = wr_count_q[ADDR_W-1:0];
        ram_wren_c = resetn & bus.next_pulse & space_c;
        if (bus.next_pulse && space_c) begin
          wr_count_d = wr_count_q + CNT_W'(1);
        end
        // Guard uses the pre-increment count so next+done on an empty RAM stays here.
        if (bus.done_pulse && (wr_count_q != '0)) begin
          state_d    = ST_P2TURN;
          rd_ptr_d   = '0;
          rd_ready_d = 1'b0;
        end
      end

      ST_P2TURN: begin
        ram_addr_c = rd_ptr_q[ADDR_W-1:0];
        // ram_q reflects mem[rd_ptr] one cycle after the address settles.
        rd_ready_d = 1'b1;
        if (bus.next_pulse && rd_ready_q) begin
          last_match_d = match_c;
          if (match_c) begin
            score_d = score_q + CNT_W'(1);
          end
          rd_ptr_d   = rd_ptr_inc_c;
          rd_ready_d = 1'b0;
          if (rd_ptr_inc_c == wr_count_q) begin
            state_d = ST_RESULT;
          end
        end
        if (bus.done_pulse) begin
          state_d = ST_RESULT;
        end
      end

      ST_RESULT: begin
        if (bus.done_pulse) begin
          state_d = ST_START;
        end
      end

      default: begin
        state_d = ST_START;
      end
    endcase

    game_over_d = (state_d == ST_RESULT);
  end

  always_ff @(posedge clock_1hz) begin
    if (!resetn) begin
      state_q      <= ST_START;
      wr_count_q   <= '0;
      rd_ptr_q     <= '0;
      score_q      <= '0;
      last_match_q <= 1'b0;
      rd_ready_q   <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_count_q   <= wr_count_d;
      rd_ptr_q     <= rd_ptr_d;
      score_q      <= score_d;
      last_match_q <= last_match_d;
      rd_ready_q   <= rd_ready_d;
      game_over_q  <= game_over_d;
    end
  end

  assign bus.ram_addr   = ram_addr_c;
  assign bus.ram_wren   = ram_wren_c;
  assign bus.ram_data   = bus.p1_value;
  assign bus.state      = state_q;
  assign bus.wr_count   = wr_count_q;
  assign bus.rd_ptr     = rd_ptr_q;
  assign bus.score      = score_q;
  assign bus.last_match = last_match_q;
  assign bus.game_over  = game_over_q;

endmodule
